// File: rtl/rob_pkg.sv
// rob_pkg: shared widths and the ROB entry layout used by rob_retire.
package rob_pkg;

    localparam int PREG_W = 6;
    localparam int ARCH_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [ARCH_W-1:0] rd;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] old_pd;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// rob_retire_sel: decides which of head / head+1 retire this cycle.
// ROB_DUAL_RETIRE_EN enables the second (head+1) retire slot.
module rob_retire_sel (
    input  logic       head_valid,
    input  logic       head_done,
    input  logic       next_valid,
    input  logic       next_done,
    output logic       ret_0,
    output logic       ret_1,
    output logic [1:0] ret_cnt
);

    always_comb begin
        ret_0 = head_valid & head_done;
`ifdef ROB_DUAL_RETIRE_EN
        ret_1 = ret_0 & next_valid & next_done;
`else
        ret_1 = 1'b0;
`endif
        ret_cnt = {1'b0, ret_0} + {1'b0, ret_1};
    end

`ifndef ROB_DUAL_RETIRE_EN
    logic unused_next;
    assign unused_next = next_valid ^ next_done;
`endif

endmodule

// File: rtl/rob_retire.sv
// rob_retire: reorder buffer with in-order retire and old-preg return.
// Define ROB_DUAL_RETIRE_EN to retire up to two entries per cycle.
module rob_retire
    import rob_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     disp_valid_0,
    input  logic                     disp_valid_1,
    input  logic [ARCH_W-1:0]        disp_rd_0,
    input  logic [ARCH_W-1:0]        disp_rd_1,
    input  logic [PREG_W-1:0]        disp_pd_0,
    input  logic [PREG_W-1:0]        disp_pd_1,
    input  logic [PREG_W-1:0]        disp_old_pd_0,
    input  logic [PREG_W-1:0]        disp_old_pd_1,
    output logic                     disp_ready,
    output logic [$clog2(DEPTH)-1:0] disp_idx_0,
    output logic [$clog2(DEPTH)-1:0] disp_idx_1,
    input  logic                     cmp_valid_0,
    input  logic                     cmp_valid_1,
    input  logic [$clog2(DEPTH)-1:0] cmp_idx_0,
    input  logic [$clog2(DEPTH)-1:0] cmp_idx_1,
    input  logic [DATA_W-1:0]        cmp_data_0,
    input  logic [DATA_W-1:0]        cmp_data_1,
    output logic                     ret_valid_0,
    output logic                     ret_valid_1,
    output logic                     ret_we_0,
    output logic                     ret_we_1,
    output logic [ARCH_W-1:0]        ret_rd_0,
    output logic [ARCH_W-1:0]        ret_rd_1,
    output logic [PREG_W-1:0]        ret_pd_0,
    output logic [PREG_W-1:0]        ret_pd_1,
    output logic [DATA_W-1:0]        ret_data_0,
    output logic [DATA_W-1:0]        ret_data_1,
    output logic                     free_valid_0,
    output logic                     free_valid_1,
    output logic [PREG_W-1:0]        free_preg_0,
    output logic [PREG_W-1:0]        free_preg_1,
    output logic                     rob_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    rob_entry_t       rob [DEPTH];
    logic [IDX_W-1:0] head, tail, head_p1, tail_p1;
    logic [CNT_W-1:0] count;
    rob_entry_t       head_ent, next_ent;
    logic             acc_0, acc_1, ret_0, ret_1, we_0, we_1;
    logic             cmp_hit_0, cmp_hit_1;
    logic [1:0]       acc_cnt, ret_cnt;

    assign head_p1    = head + IDX_W'(1);
    assign tail_p1    = tail + IDX_W'(1);
    assign head_ent   = rob[head];
    assign next_ent   = rob[head_p1];
    assign disp_ready = count <= CNT_W'(DEPTH - 2);
    assign rob_empty  = count == '0;
    assign disp_idx_0 = tail;
    assign disp_idx_1 = tail_p1;
    assign acc_0      = disp_ready & disp_valid_0;
    assign acc_1      = acc_0 & disp_valid_1;
    assign acc_cnt    = {1'b0, acc_0} + {1'b0, acc_1};
    assign we_0       = ret_0 & (head_ent.rd != '0);
    assign we_1       = ret_1 & (next_ent.rd != '0);
    // Completions only land on live, not-yet-done entries; stale indices drop.
    assign cmp_hit_0  = cmp_valid_0 & rob[cmp_idx_0].valid & ~rob[cmp_idx_0].done;
    assign cmp_hit_1  = cmp_valid_1 & rob[cmp_idx_1].valid & ~rob[cmp_idx_1].done;

    rob_retire_sel u_sel (
        .head_valid (head_ent.valid),
        .head_done  (head_ent.done),
        .next_valid (next_ent.valid),
        .next_done  (next_ent.done),
        .ret_0      (ret_0),
        .ret_1      (ret_1),
        .ret_cnt    (ret_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) rob[i] <= '0;
            ret_valid_0  <= 1'b0;
            ret_valid_1  <= 1'b0;
            ret_we_0     <= 1'b0;
            ret_we_1     <= 1'b0;
            ret_rd_0     <= '0;
            ret_rd_1     <= '0;
            ret_pd_0     <= '0;
            ret_pd_1     <= '0;
            ret_data_0   <= '0;
            ret_data_1   <= '0;
            free_valid_0 <= 1'b0;
            free_valid_1 <= 1'b0;
            free_preg_0  <= '0;
            free_preg_1  <= '0;
        end else begin
            ret_valid_0  <= ret_0;
            ret_valid_1  <= ret_1;
            ret_we_0     <= we_0;
            ret_we_1     <= we_1;
            ret_rd_0     <= ret_0 ? head_ent.rd   : '0;
            ret_rd_1     <= ret_1 ? next_ent.rd   : '0;
            ret_pd_0     <= ret_0 ? head_ent.pd   : '0;
            ret_pd_1     <= ret_1 ? next_ent.pd   : '0;
            ret_data_0   <= ret_0 ? head_ent.data : '0;
            ret_data_1   <= ret_1 ? next_ent.data : '0;
            free_valid_0 <= we_0;
            free_valid_1 <= we_1;
            free_preg_0  <= we_0 ? head_ent.old_pd : '0;
            free_preg_1  <= we_1 ? next_ent.old_pd : '0;

            // Retiring, dispatched and completing slots never coincide, so write order is free.
            if (ret_0) rob[head]    <= '0;
            if (ret_1) rob[head_p1] <= '0;
            if (acc_0) rob[tail]    <= '{1'b1, 1'b0, disp_rd_0, disp_pd_0, disp_old_pd_0, '0};
            if (acc_1) rob[tail_p1] <= '{1'b1, 1'b0, disp_rd_1, disp_pd_1, disp_old_pd_1, '0};
            if (cmp_hit_1) begin
                rob[cmp_idx_1].done <= 1'b1;
                rob[cmp_idx_1].data <= cmp_data_1;
            end
            if (cmp_hit_0) begin
                rob[cmp_idx_0].done <= 1'b1;
                rob[cmp_idx_0].data <= cmp_data_0;
            end

            head  <= head + IDX_W'(ret_cnt);
            tail  <= tail + IDX_W'(acc_cnt);
            count <= count + CNT_W'(acc_cnt) - CNT_W'(ret_cnt);
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: directed and random checks of rob_retire against a queue-based program-order model.
module tb_rob_retire;
    import rob_pkg::*;

    localparam int DEPTH = 16;
    localparam int IW    = $clog2(DEPTH);
`ifdef ROB_DUAL_RETIRE_EN
    localparam int RW = 2;
`else
    localparam int RW = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              disp_valid_0, disp_valid_1;
    logic [ARCH_W-1:0] disp_rd_0, disp_rd_1;
    logic [PREG_W-1:0] disp_pd_0, disp_pd_1, disp_old_pd_0, disp_old_pd_1;
    logic              disp_ready;
    logic [IW-1:0]     disp_idx_0, disp_idx_1;
    logic              cmp_valid_0, cmp_valid_1;
    logic [IW-1:0]     cmp_idx_0, cmp_idx_1;
    logic [DATA_W-1:0] cmp_data_0, cmp_data_1;
    logic              ret_valid_0, ret_valid_1, ret_we_0, ret_we_1;
    logic [ARCH_W-1:0] ret_rd_0, ret_rd_1;
    logic [PREG_W-1:0] ret_pd_0, ret_pd_1;
    logic [DATA_W-1:0] ret_data_0, ret_data_1;
    logic              free_valid_0, free_valid_1;
    logic [PREG_W-1:0] free_preg_0, free_preg_1;
    logic              rob_empty;

    always #5 clk = ~clk;

    rob_retire #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid_0(disp_valid_0), .disp_valid_1(disp_valid_1),
        .disp_rd_0(disp_rd_0), .disp_rd_1(disp_rd_1),
        .disp_pd_0(disp_pd_0), .disp_pd_1(disp_pd_1),
        .disp_old_pd_0(disp_old_pd_0), .disp_old_pd_1(disp_old_pd_1),
        .disp_ready(disp_ready), .disp_idx_0(disp_idx_0), .disp_idx_1(disp_idx_1),
        .cmp_valid_0(cmp_valid_0), .cmp_valid_1(cmp_valid_1),
        .cmp_idx_0(cmp_idx_0), .cmp_idx_1(cmp_idx_1),
        .cmp_data_0(cmp_data_0), .cmp_data_1(cmp_data_1),
        .ret_valid_0(ret_valid_0), .ret_valid_1(ret_valid_1),
        .ret_we_0(ret_we_0), .ret_we_1(ret_we_1),
        .ret_rd_0(ret_rd_0), .ret_rd_1(ret_rd_1),
        .ret_pd_0(ret_pd_0), .ret_pd_1(ret_pd_1),
        .ret_data_0(ret_data_0), .ret_data_1(ret_data_1),
        .free_valid_0(free_valid_0), .free_valid_1(free_valid_1),
        .free_preg_0(free_preg_0), .free_preg_1(free_preg_1),
        .rob_empty(rob_empty)
    );

    // Per-slot views of the retire outputs
    logic              act_rv[2], act_we[2], act_fv[2];
    logic [ARCH_W-1:0] act_rd[2];
    logic [PREG_W-1:0] act_pd[2], act_fp[2];
    logic [DATA_W-1:0] act_data[2];
    assign act_rv[0] = ret_valid_0;   assign act_rv[1] = ret_valid_1;
    assign act_we[0] = ret_we_0;      assign act_we[1] = ret_we_1;
    assign act_fv[0] = free_valid_0;  assign act_fv[1] = free_valid_1;
    assign act_rd[0] = ret_rd_0;      assign act_rd[1] = ret_rd_1;
    assign act_pd[0] = ret_pd_0;      assign act_pd[1] = ret_pd_1;
    assign act_fp[0] = free_preg_0;   assign act_fp[1] = free_preg_1;
    assign act_data[0] = ret_data_0;  assign act_data[1] = ret_data_1;

    // Reference model: program-order list of in-flight instructions.
    typedef struct {
        int                idx;
        logic [ARCH_W-1:0] rd;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] old;
        logic              done;
        logic [DATA_W-1:0] data;
    } m_ent_t;

    m_ent_t            mq[$];
    int                m_tail = 0;
    logic              exp_rv[2], exp_we[2], exp_fv[2];
    logic [ARCH_W-1:0] exp_rd[2];
    logic [PREG_W-1:0] exp_pd[2], exp_fp[2];
    logic [DATA_W-1:0] exp_data[2];
    int                checks = 0;
    int                errors = 0;

    task automatic set_idle;
        disp_valid_0 = 0; disp_valid_1 = 0;
        disp_rd_0 = '0; disp_rd_1 = '0; disp_pd_0 = '0; disp_pd_1 = '0;
        disp_old_pd_0 = '0; disp_old_pd_1 = '0;
        cmp_valid_0 = 0; cmp_valid_1 = 0;
        cmp_idx_0 = '0; cmp_idx_1 = '0; cmp_data_0 = '0; cmp_data_1 = '0;
    endtask

    task automatic drive_disp(input bit v0, input int rd0, input int pd0, input int od0,
                              input bit v1, input int rd1, input int pd1, input int od1);
        disp_valid_0 = v0; disp_rd_0 = ARCH_W'(rd0); disp_pd_0 = PREG_W'(pd0); disp_old_pd_0 = PREG_W'(od0);
        disp_valid_1 = v1; disp_rd_1 = ARCH_W'(rd1); disp_pd_1 = PREG_W'(pd1); disp_old_pd_1 = PREG_W'(od1);
    endtask

    task automatic drive_cmp(input bit v0, input int i0, input int d0,
                             input bit v1, input int i1, input int d1);
        cmp_valid_0 = v0; cmp_idx_0 = IW'(i0); cmp_data_0 = DATA_W'(d0);
        cmp_valid_1 = v1; cmp_idx_1 = IW'(i1); cmp_data_1 = DATA_W'(d1);
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic clk_step;
        int nret = 0;
        int h0 = -1;
        int h1 = -1;
        bit rdy;
        rdy = (mq.size() <= DEPTH - 2);
        for (int s = 0; s < 2; s++) begin
            exp_rv[s] = 0; exp_we[s] = 0; exp_fv[s] = 0;
            exp_rd[s] = '0; exp_pd[s] = '0; exp_fp[s] = '0; exp_data[s] = '0;
        end
        while (nret < RW && nret < mq.size() && mq[nret].done) begin
            exp_rv[nret]   = 1;
            exp_rd[nret]   = mq[nret].rd;
            exp_pd[nret]   = mq[nret].pd;
            exp_data[nret] = mq[nret].data;
            exp_we[nret]   = (mq[nret].rd != 0);
            exp_fv[nret]   = (mq[nret].rd != 0);
            exp_fp[nret]   = mq[nret].old;
            nret++;
        end
        if (cmp_valid_0)
            foreach (mq[k]) if (mq[k].idx == int'(cmp_idx_0) && !mq[k].done) h0 = k;
        if (cmp_valid_1 && !(cmp_valid_0 && cmp_idx_0 == cmp_idx_1))
            foreach (mq[k]) if (mq[k].idx == int'(cmp_idx_1) && !mq[k].done) h1 = k;
        if (h0 >= 0) begin mq[h0].done = 1; mq[h0].data = cmp_data_0; end
        if (h1 >= 0) begin mq[h1].done = 1; mq[h1].data = cmp_data_1; end
        repeat (nret) void'(mq.pop_front());
        if (rdy && disp_valid_0) begin
            mq.push_back('{m_tail, disp_rd_0, disp_pd_0, disp_old_pd_0, 1'b0, '0});
            m_tail = (m_tail + 1) % DEPTH;
            if (disp_valid_1) begin
                mq.push_back('{m_tail, disp_rd_1, disp_pd_1, disp_old_pd_1, 1'b0, '0});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        set_idle;
        rst_n = 0;
        mq.delete();
        m_tail = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        set_idle;
        rst_n = 0;
        #1;
        checks++;
        if (rob_empty !== 1'b1 || disp_ready !== 1'b1) begin
            errors++; $display("FAIL reset_status: empty=%b ready=%b, expected 1 1", rob_empty, disp_ready);
        end
        checks++;
        if (disp_idx_0 !== IW'(0) || disp_idx_1 !== IW'(1)) begin
            errors++; $display("FAIL reset_idx: idx0=%0d idx1=%0d, expected 0 1", disp_idx_0, disp_idx_1);
        end
        checks++;
        if ({ret_valid_0, ret_valid_1, ret_we_0, ret_we_1, free_valid_0, free_valid_1} !== '0) begin
            errors++; $display("FAIL reset_pulses: got %b%b%b%b%b%b, expected 000000", ret_valid_0, ret_valid_1,
                               ret_we_0, ret_we_1, free_valid_0, free_valid_1);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        // Build 5 entries, complete the first two, then reset while a retire pulse is showing.
        drive_disp(1, 1, 41, 11, 1, 2, 42, 12); clk_step;
        drive_disp(1, 3, 43, 13, 1, 4, 44, 14); clk_step;
        drive_disp(1, 5, 45, 15, 0, 0, 0, 0);   clk_step;
        set_idle;
        drive_cmp(1, 0, 32'h100, 1, 1, 32'h101); clk_step;
        set_idle;
        clk_step;
        checks++;
        if (ret_valid_0 !== 1'b1 || ret_pd_0 !== PREG_W'(41)) begin
            errors++; $display("FAIL prereset_retire: valid=%b pd=%0d, expected 1 41", ret_valid_0, ret_pd_0);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({ret_valid_0, ret_valid_1, ret_we_0, ret_we_1, free_valid_0, free_valid_1} !== '0 || rob_empty !== 1'b1) begin
            errors++; $display("FAIL async_reset: pulses=%b%b%b%b%b%b empty=%b, expected all 0, empty 1",
                               ret_valid_0, ret_valid_1, ret_we_0, ret_we_1, free_valid_0, free_valid_1, rob_empty);
        end
        checks++;
        if ({ret_rd_0, ret_rd_1, ret_pd_0, ret_pd_1, ret_data_0, ret_data_1, free_preg_0, free_preg_1} !== '0) begin
            errors++; $display("FAIL async_reset_payload: pd0=%0d data0=%h fp0=%0d, expected 0", ret_pd_0, ret_data_0, free_preg_0);
        end
        mq.delete();
        m_tail = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        // Completions aimed at discarded entries must not revive them.
        drive_cmp(1, 2, 32'h102, 1, 3, 32'h103); clk_step;
        set_idle;
        for (int c = 0; c < 3; c++) begin
            clk_step;
            checks++;
            if ({ret_valid_0, ret_valid_1, free_valid_0, free_valid_1} !== '0 || rob_empty !== 1'b1) begin
                errors++; $display("FAIL post_reset_quiet c%0d: rv=%b%b fv=%b%b empty=%b, expected 0000 1",
                                   c, ret_valid_0, ret_valid_1, free_valid_0, free_valid_1, rob_empty);
            end
        end
        checks++;
        if (disp_idx_0 !== IW'(0)) begin
            errors++; $display("FAIL post_reset_tail: idx0=%0d, expected 0", disp_idx_0);
        end
    endtask

    task automatic test_pair_retire;
        int got_pd[$];
        int got_fp[$];
        logic [DATA_W-1:0] got_data[$];
        drive_disp(1, 3, 33, 3, 1, 4, 34, 4); clk_step;
        set_idle;
        drive_cmp(0, 0, 0, 1, 1, 32'hB); clk_step;
        set_idle;
        checks++;
        if (ret_valid_0 !== 1'b0) begin
            errors++; $display("FAIL pair_early_retire: ret_valid_0=%b, expected 0", ret_valid_0);
        end
        drive_cmp(1, 0, 32'hA, 0, 0, 0); clk_step;
        set_idle;
        checks++;
        if (ret_valid_0 !== 1'b0) begin
            errors++; $display("FAIL pair_no_bypass: ret_valid_0=%b, expected 0", ret_valid_0);
        end
        for (int c = 0; c < 3; c++) begin
            clk_step;
            if (c == 0) begin
                checks++;
                if (ret_valid_0 !== 1'b1 || ret_pd_0 !== PREG_W'(33)) begin
                    errors++; $display("FAIL pair_latency: valid=%b pd=%0d, expected 1 33", ret_valid_0, ret_pd_0);
                end
            end
            for (int s = 0; s < 2; s++)
                if (act_rv[s] === 1'b1) begin
                    got_pd.push_back(int'(act_pd[s]));
                    got_fp.push_back(int'(act_fp[s]));
                    got_data.push_back(act_data[s]);
                end
        end
        checks++;
        if (got_pd.size() != 2) begin
            errors++; $display("FAIL pair_count: retired %0d, expected 2", got_pd.size());
        end else begin
            checks++;
            if (got_pd[0] != 33 || got_pd[1] != 34 || got_fp[0] != 3 || got_fp[1] != 4) begin
                errors++; $display("FAIL pair_order: pd %0d/%0d free %0d/%0d, expected 33/34 3/4",
                                   got_pd[0], got_pd[1], got_fp[0], got_fp[1]);
            end
            checks++;
            if (got_data[0] !== 32'hA || got_data[1] !== 32'hB) begin
                errors++; $display("FAIL pair_data: %h/%h, expected a/b", got_data[0], got_data[1]);
            end
        end
    endtask

    task automatic test_out_of_order;
        int got_pd[$];
        int base;
        base = m_tail;
        checks++;
        if (disp_idx_0 !== IW'(base)) begin
            errors++; $display("FAIL ooo_idx: idx0=%0d, expected %0d", disp_idx_0, base);
        end
        drive_disp(1, 5, 35, 5, 1, 6, 36, 6); clk_step;
        set_idle;
        drive_cmp(1, (base + 1) % DEPTH, 32'h33, 0, 0, 0); clk_step;
        set_idle;
        for (int c = 0; c < 3; c++) begin
            clk_step;
            checks++;
            if (ret_valid_0 !== 1'b0 || ret_valid_1 !== 1'b0) begin
                errors++; $display("FAIL ooo_blocked c%0d: rv=%b%b, expected 00", c, ret_valid_0, ret_valid_1);
            end
        end
        drive_cmp(1, base, 32'h22, 0, 0, 0); clk_step;
        set_idle;
        for (int c = 0; c < 3; c++) begin
            clk_step;
            for (int s = 0; s < 2; s++) if (act_rv[s] === 1'b1) got_pd.push_back(int'(act_pd[s]));
        end
        checks++;
        if (got_pd.size() != 2 || got_pd[0] != 35 || got_pd[1] != 36) begin
            errors++; $display("FAIL ooo_order: retired %0d entries (first pd %0d), expected 35 then 36",
                               got_pd.size(), got_pd.size() > 0 ? got_pd[0] : -1);
        end
    endtask

    task automatic test_rd_zero;
        int base;
        base = m_tail;
        drive_disp(0, 0, 0, 0, 1, 7, 41, 9); clk_step;
        set_idle;
        checks++;
        if (disp_idx_0 !== IW'(base) || rob_empty !== 1'b1) begin
            errors++; $display("FAIL slot1_alone: idx0=%0d empty=%b, expected %0d 1", disp_idx_0, rob_empty, base);
        end
        drive_disp(1, 0, 40, 12, 0, 0, 0, 0); clk_step;
        set_idle;
        drive_cmp(1, base, 32'h5A5A, 0, 0, 0); clk_step;
        set_idle;
        clk_step;
        checks++;
        if (ret_valid_0 !== 1'b1 || ret_we_0 !== 1'b0 || free_valid_0 !== 1'b0 || ret_pd_0 !== PREG_W'(40)) begin
            errors++; $display("FAIL rd_zero: valid=%b we=%b free=%b pd=%0d, expected 1 0 0 40",
                               ret_valid_0, ret_we_0, free_valid_0, ret_pd_0);
        end
    endtask

    task automatic test_drain(input string tag);
        int budget = 100;
        int n;
        while (mq.size() > 0 && budget > 0) begin
            set_idle;
            n = 0;
            foreach (mq[k])
                if (!mq[k].done && n < 2) begin
                    if (n == 0) drive_cmp(1, mq[k].idx, $urandom, cmp_valid_1, int'(cmp_idx_1), int'(cmp_data_1));
                    else        drive_cmp(cmp_valid_0, int'(cmp_idx_0), int'(cmp_data_0), 1, mq[k].idx, $urandom);
                    n++;
                end
            clk_step;
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (act_rv[s] !== exp_rv[s] || act_fv[s] !== exp_fv[s] ||
                    (exp_rv[s] && act_pd[s] !== exp_pd[s]) || (exp_fv[s] && act_fp[s] !== exp_fp[s])) begin
                    errors++; $display("FAIL %s_drain slot%0d: rv=%b fv=%b pd=%0d fp=%0d, expected %b %b %0d %0d", tag, s,
                                       act_rv[s], act_fv[s], act_pd[s], act_fp[s], exp_rv[s], exp_fv[s], exp_pd[s], exp_fp[s]);
                end
            end
            budget--;
        end
        set_idle;
        checks++;
        if (mq.size() != 0 || rob_empty !== 1'b1) begin
            errors++; $display("FAIL %s_drain_end: model left %0d, rob_empty=%b, expected 0 1", tag, mq.size(), rob_empty);
        end
    endtask

    task automatic test_full_wrap;
        do_reset;
        for (int i = 0; i < 7; i++) begin
            drive_disp(1, i + 1, 8 + 2 * i, 30 + i, 1, i + 9, 9 + 2 * i, 40 + i);
            clk_step;
        end
        set_idle;
        checks++;
        if (disp_ready !== 1'b1) begin
            errors++; $display("FAIL ready_at_14: disp_ready=%b, expected 1", disp_ready);
        end
        drive_disp(1, 20, 22, 50, 0, 0, 0, 0); clk_step;
        set_idle;
        checks++;
        if (disp_ready !== 1'b0 || disp_idx_0 !== IW'(15)) begin
            errors++; $display("FAIL full_15: ready=%b idx0=%0d, expected 0 15", disp_ready, disp_idx_0);
        end
        drive_disp(1, 21, 23, 51, 1, 22, 24, 52); clk_step;
        set_idle;
        checks++;
        if (disp_idx_0 !== IW'(15) || mq.size() != 15) begin
            errors++; $display("FAIL full_reject: idx0=%0d model=%0d, expected 15 15", disp_idx_0, mq.size());
        end
        drive_cmp(1, 0, 32'h1000, 1, 1, 32'h1001); clk_step;
        drive_cmp(1, 2, 32'h1002, 1, 3, 32'h1003); clk_step;
        set_idle;
        checks++;
        if (disp_ready !== 1'b1 || disp_idx_0 !== IW'(15) || disp_idx_1 !== IW'(0)) begin
            errors++; $display("FAIL wrap_pre: ready=%b idx=%0d/%0d, expected 1 15/0", disp_ready, disp_idx_0, disp_idx_1);
        end
        drive_disp(1, 23, 60, 53, 1, 24, 61, 54); clk_step;
        set_idle;
        checks++;
        if (disp_idx_0 !== IW'(1) || ret_valid_0 !== 1'b1 || ret_valid_1 !== exp_rv[1]) begin
            errors++; $display("FAIL wrap_post: idx0=%0d rv=%b%b, expected 1 1%b", disp_idx_0, ret_valid_0, ret_valid_1, exp_rv[1]);
        end
        checks++;
        if (disp_ready !== (mq.size() <= DEPTH - 2)) begin
            errors++; $display("FAIL wrap_count: ready=%b, expected %b", disp_ready, mq.size() <= DEPTH - 2);
        end
        test_drain("wrap");
    endtask

    task automatic test_retire_rate;
        int total = 0;
        int base;
        base = m_tail;
        drive_disp(1, 8, 50, 20, 1, 9, 51, 21); clk_step;
        set_idle;
        drive_cmp(1, base, 32'hC0, 1, (base + 1) % DEPTH, 32'hC1); clk_step;
        set_idle;
        for (int c = 0; c < 3; c++) begin
            clk_step;
            checks++;
            if (ret_valid_0 !== exp_rv[0] || ret_valid_1 !== exp_rv[1]) begin
                errors++; $display("FAIL retire_rate c%0d: rv=%b%b, expected %b%b", c, ret_valid_0, ret_valid_1, exp_rv[0], exp_rv[1]);
            end
            total += int'(ret_valid_0 === 1'b1) + int'(ret_valid_1 === 1'b1);
        end
        checks++;
        if (total != 2) begin
            errors++; $display("FAIL retire_rate_total: retired %0d, expected 2", total);
        end
    endtask

    task automatic test_random;
        int k;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++;
            if (disp_ready !== (mq.size() <= DEPTH - 2) || rob_empty !== (mq.size() == 0) ||
                disp_idx_0 !== IW'(m_tail) || disp_idx_1 !== IW'((m_tail + 1) % DEPTH)) begin
                errors++; $display("FAIL rand_status cyc%0d: ready=%b empty=%b idx=%0d/%0d, expected %b %b %0d/%0d", cyc,
                                   disp_ready, rob_empty, disp_idx_0, disp_idx_1, mq.size() <= DEPTH - 2,
                                   mq.size() == 0, m_tail, (m_tail + 1) % DEPTH);
            end
            set_idle;
            drive_disp($urandom_range(0, 9) < 6,
                       ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31), $urandom_range(0, 63), $urandom_range(0, 63),
                       $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, mq.size() - 1);
                drive_cmp(1, mq[k].idx, $urandom, 0, 0, 0);
                k = $urandom_range(0, mq.size() - 1);
                if ($urandom_range(0, 1) == 1) drive_cmp(1, int'(cmp_idx_0), int'(cmp_data_0), 1,
                                                          ($urandom_range(0, 5) == 0) ? int'(cmp_idx_0) : mq[k].idx, $urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                drive_cmp(1, $urandom_range(0, DEPTH - 1), $urandom, 1, $urandom_range(0, DEPTH - 1), $urandom);
            end
            clk_step;
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (act_rv[s] !== exp_rv[s] || act_we[s] !== exp_we[s] || act_fv[s] !== exp_fv[s]) begin
                    errors++; $display("FAIL rand_flags cyc%0d slot%0d: v/we/fv=%b%b%b, expected %b%b%b", cyc, s,
                                       act_rv[s], act_we[s], act_fv[s], exp_rv[s], exp_we[s], exp_fv[s]);
                end
                if (exp_rv[s]) begin
                    checks++;
                    if (act_rd[s] !== exp_rd[s] || act_pd[s] !== exp_pd[s] || act_data[s] !== exp_data[s]) begin
                        errors++; $display("FAIL rand_payload cyc%0d slot%0d: rd=%0d pd=%0d data=%h, expected %0d %0d %h", cyc, s,
                                           act_rd[s], act_pd[s], act_data[s], exp_rd[s], exp_pd[s], exp_data[s]);
                    end
                end
                if (exp_fv[s]) begin
                    checks++;
                    if (act_fp[s] !== exp_fp[s]) begin
                        errors++; $display("FAIL rand_free cyc%0d slot%0d: preg=%0d, expected %0d", cyc, s, act_fp[s], exp_fp[s]);
                    end
                end
            end
        end
        set_idle;
        test_drain("rand");
    endtask

    initial begin
        set_idle;
        test_reset;
        test_pair_retire;
        test_out_of_order;
        test_rd_zero;
        test_full_wrap;
        test_retire_rate;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rob_retire.md
# rob_retire

Reorder buffer and in-order retire unit: the release end of register renaming. It accepts up to two renamed instructions per cycle from rename, with their destination and previous physical mappings, and records out-of-order completions from the ALUs. It retires completed instructions strictly in program order, writes results to the architectural side, and returns each superseded physical register to the free pool.

## Interface
- DEPTH, 16, ROB entries; power of two, at least 4
- PREG_W, 6, physical register index width (64 pregs)
- ARCH_W, 5, architectural register index width
- DATA_W, 32, result width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- disp_valid_0 / disp_valid_1  in  1  dispatch slot valid; slot 1 legal only with slot 0
- disp_rd_0/1  in  ARCH_W  architectural destination
- disp_pd_0/1  in  PREG_W  new physical destination
- disp_old_pd_0/1  in  PREG_W  previous mapping of rd, to be freed at retire
- disp_ready  out  1  at least 2 free entries (combinational from count)
- disp_idx_0 / disp_idx_1  out  $clog2(DEPTH)  ROB index given to slot 0 / slot 1 (tail, tail+1)
- cmp_valid_0/1  in  1  completion valid
- cmp_idx_0/1  in  $clog2(DEPTH)  completing entry
- cmp_data_0/1  in  DATA_W  result
- ret_valid_0/1  out  1  registered: instruction retired
- ret_we_0/1  out  1  registered: ret_valid and rd != 0
- ret_rd_0/1, ret_pd_0/1, ret_data_0/1  out  ARCH_W/PREG_W/DATA_W  retired destination, preg, result
- free_valid_0/1  out  1  registered: return free_preg to free pool
- free_preg_0/1  out  PREG_W  preg being freed (the old_pd)
- rob_empty  out  1  count == 0

## Operation
- Circular buffer: head, tail pointers and count (0..DEPTH); pointers wrap mod DEPTH.
- Entry: valid, done, rd, pd, old_pd, data.
- Dispatch: accepted only when disp_ready. Slot 0 writes at tail, slot 1 at tail+1; tail advances by number accepted. disp_valid_1 without disp_valid_0 is ignored (no write, no tail move).
- Completion: sets done and stores data on a valid, not-done entry; otherwise ignored. Both ports on the same index: port 0 wins.
- Retire: entry at head retires if valid and done. Head+1 retires in the same cycle only if head retires and head+1 is valid and done. Retired entries are cleared, and head advances by the number retired.
- Free: free_valid is set for a retiring entry when rd != 0. With rd == 0, the instruction still retires with ret_we = 0 and nothing is freed.
- count next = count + accepted − retired; simultaneous dispatch and retire are legal.

## Timing
- Reset (async, rst_n low): head = tail = count = 0, all entry valid/done = 0. All ret_*, free_* outputs 0, disp_ready = 1, rob_empty = 1, disp_idx_0 = 0, disp_idx_1 = 1. Reset mid-operation discards all entries, with no retire or free pulses.
- Dispatch at edge N makes the entry eligible for completion from cycle N+1.
- Completion at edge N is retire-visible after N; ret_*/free_* are asserted for exactly one cycle following edge N+1 (2-edge latency complete-to-retire).
- Completion and retire of the same entry at the same edge: the retire uses the pre-edge done flag, so no bypass.
- Full (count > DEPTH−2): disp_ready = 0, no writes. Empty: no retire.
- Retired slots are reusable by dispatch at the edge after they are cleared.

## Configuration
- ROB_DUAL_RETIRE_EN defined: up to 2 retirements per cycle as above.
- ROB_DUAL_RETIRE_EN undefined: head only, at most one retirement per cycle; ret_*_1 and free_*_1 are tied to 0.

## Structure
- Package rob_pkg: PREG_W, ARCH_W, DATA_W constants and the rob_entry_t struct (valid, done, rd, pd, old_pd, data).
- One sub-module, rob_retire_sel: combinational head/head+1 eligibility and retire-count selection, parameterised by the dual-retire macro.

## Test plan
- Reset: hold rst_n low mid-run with 5 entries -> all outputs zero, rob_empty = 1, no free pulses after release.
- Dispatch {rd 3, pd 33, old 3} and {rd 4, pd 34, old 4} as idx 0/1. Complete idx 1 (0xB), then idx 0 (0xA) -> both retire in one cycle in order: ret_pd 33/34, data 0xA/0xB, free_preg 3/4.
- Complete idx 1 only -> no retire until idx 0 completes.
- rd = 0 entry completes -> ret_valid = 1, ret_we = 0, free_valid = 0.
- Fill to 15 entries -> disp_ready = 0. Retire 2 with dispatch 2 in the same cycle -> count unchanged; tail wraps 15 -> 1 correctly.
- Macro undefined: two completed head entries -> retired on consecutive cycles; ret_valid_1 never asserted.
